// File: rtl/boot_loader_pkg.sv
// Shared types and command codes for the SPI boot loader.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_WRITE,
        S_IGNORE
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'hA5;
    localparam logic [7:0] CMD_RUN  = 8'h5A;
    localparam logic [7:0] CMD_HOLD = 8'hC3;

endpackage

// File: rtl/spi_boot_loader_sync_2ff.sv
// Two-flop synchronizer with a per-bit reset value.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/spi_boot_loader.sv
// SPI-slave program loader: fills the instruction RAM and holds the CPU
// in reset until a RUN command arrives.
module spi_boot_loader
    import boot_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [ADDR_WIDTH:0] WC_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic sclk_s, cs_s, mosi_s;

    sync_2ff #(.WIDTH(3), .RST_VAL(3'b010)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     ({sclk, cs_n, mosi}),
        .q     ({sclk_s, cs_s, mosi_s})
    );

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   wc_q, wc_d;
    logic                  hold_q, hold_d;
    logic                  miso_q, miso_d;
    logic [7:0]            stat_q, stat_d;
    logic                  sclk_prev_q, sclk_prev_d;
    logic                  cs_prev_q, cs_prev_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;
    logic                  cs_rise_q, cs_rise_d;
    logic                  cs_fall_q, cs_fall_d;
    logic [1:0]            valid_q, valid_d;
    logic                  armed_q, armed_d;

    logic [DATA_WIDTH-1:0] shift_in;
    logic [7:0]            byte_in;
    logic [CW-1:0]         cnt_inc;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            wc_q        <= '0;
            hold_q      <= 1'b1;
            miso_q      <= 1'b0;
            stat_q      <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
            valid_q     <= '0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            wc_q        <= wc_d;
            hold_q      <= hold_d;
            miso_q      <= miso_d;
            stat_q      <= stat_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            cs_rise_q   <= cs_rise_d;
            cs_fall_q   <= cs_fall_d;
            valid_q     <= valid_d;
            armed_q     <= armed_d;
        end
    end

    assign shift_in = {shift_q[DATA_WIDTH-2:0], mosi_s};
    assign byte_in  = shift_in[7:0];
    assign cnt_inc  = cnt_q + 1'b1;

    always_comb begin
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        rise_d      = sclk_s & ~sclk_prev_q;
        fall_d      = ~sclk_s & sclk_prev_q;
        cs_rise_d   = cs_s & ~cs_prev_q;
        // A frame already in progress at reset release is never armed.
        valid_d     = {valid_q[0], 1'b1};
        armed_d     = armed_q | (valid_q[1] & cs_s);
        cs_fall_d   = armed_q & cs_prev_q & ~cs_s;

        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        addr_d  = addr_q;
        wc_d    = wc_q;
        hold_d  = hold_q;
        miso_d  = 1'b0;
        stat_d  = stat_q;

        case (state_q)
            S_IDLE: begin
                if (cs_fall_q) begin
                    state_d = S_CMD;
                    cnt_d   = '0;
                    stat_d  = {hold_q, wc_q == '0, 6'b0};
                    miso_d  = hold_q;
                end
            end
            S_CMD: begin
                miso_d = miso_q;
                if (fall_q) begin
                    stat_d = {stat_q[6:0], 1'b0};
                    miso_d = stat_q[6];
                end
                if (rise_q) begin
                    shift_d = shift_in;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == CW'(8)) begin
                        cnt_d   = '0;
                        state_d = S_IGNORE;
                        if (byte_in == CMD_LOAD && hold_q) begin
                            state_d = S_ADDR;
                            wc_d    = '0;
                        end else if (byte_in == CMD_RUN) begin
                            hold_d = 1'b0;
                        end else if (byte_in == CMD_HOLD) begin
                            hold_d = 1'b1;
                        end
                    end
                end
            end
            S_ADDR: begin
                if (rise_q) begin
                    shift_d = shift_in;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == CW'(8)) begin
                        cnt_d   = '0;
                        addr_d  = ADDR_WIDTH'(byte_in);
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rise_q) begin
                    shift_d = shift_in;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == CW'(DATA_WIDTH)) begin
                        cnt_d   = '0;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + 1'b1;
                wc_d    = (wc_q == WC_MAX) ? wc_q : wc_q + 1'b1;
                state_d = S_DATA;
            end
            default: ;
        endcase

        // The strobe of a WRITE cycle still completes when cs_n rises with it.
        if (cs_rise_q) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            miso_d  = 1'b0;
        end
    end

    always_comb begin
        mem_en     = (state_q == S_WRITE);
        mem_we     = (state_q == S_WRITE);
        mem_addr   = (state_q == S_WRITE) ? addr_q : '0;
        mem_wdata  = (state_q == S_WRITE) ? shift_q : '0;
        cpu_hold   = hold_q;
        miso       = miso_q;
        word_count = wc_q;
    end

endmodule

// File: tb/tb_spi_boot_loader.sv
// Scoreboard bench for spi_boot_loader: SPI master stimulus, write
// expectations queued and checked as the RAM strobes appear.
module tb_spi_boot_loader;

    localparam int HALF = 6;

    logic        clock = 1'b0;
    logic        reset;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic [8:0]  word_count;

    int total = 0;
    int bad   = 0;

    logic [39:0] exp_q[$];
    logic [31:0] ram [256];
    logic [31:0] words [4];
    logic [31:0] r;

    always #5 clock = ~clock;

    spi_boot_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .miso       (miso),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .word_count (word_count)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && mem_en) begin
            chk("we", {63'b0, mem_we}, 64'd1);
            ram[mem_addr] = mem_wdata;
            if (exp_q.size() == 0)
                chk("wr_unexp", 64'd1, 64'd0);
            else
                chk("wr", {24'b0, mem_addr, mem_wdata}, {24'b0, exp_q.pop_front()});
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic spi_bits(input logic [31:0] v, input int n,
                            output logic [31:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = v[i];
            wait_clks(HALF);
            rx = {rx[30:0], miso};
            sclk = 1'b1;
            wait_clks(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic frame_start();
        cs_n = 1'b0;
        wait_clks(8);
    endtask

    task automatic frame_end();
        wait_clks(HALF);
        cs_n = 1'b1;
        wait_clks(10);
    endtask

    initial begin
        reset = 1'b1;
        sclk  = 1'b0;
        cs_n  = 1'b1;
        mosi  = 1'b0;
        words[0] = 32'h0000_1002;
        words[1] = 32'h0000_1312;
        words[2] = 32'h0000_2412;
        words[3] = 32'h0000_0000;
        for (int i = 0; i < 256; i++) ram[i] = 32'hxxxx_xxxx;
        wait_clks(3);
        reset = 1'b0;
        wait_clks(1);
        chk("rst_hold", {63'b0, cpu_hold}, 64'd1);
        chk("rst_en", {63'b0, mem_en}, 64'd0);
        chk("rst_wc", {55'b0, word_count}, 64'd0);
        chk("rst_miso", {63'b0, miso}, 64'd0);
        wait_clks(4);

        frame_start();
        spi_bits(32'hA5, 8, r);
        chk("stat_rst", {32'b0, r}, 64'hC0);
        spi_bits(32'h00, 8, r);
        chk("miso_idle", {32'b0, r}, 64'h0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({8'(i), words[i]});
            spi_bits(words[i], 32, r);
        end
        frame_end();
        chk("load_wc", {55'b0, word_count}, 64'd4);
        chk("load_q", exp_q.size(), 0);
        for (int i = 0; i < 4; i++)
            chk("readback", {32'b0, ram[i]}, {32'b0, words[i]});

        frame_start();
        spi_bits(32'h00, 8, r);
        chk("stat_load", {32'b0, r}, 64'h80);
        frame_end();

        frame_start();
        spi_bits(32'hA5, 8, r);
        spi_bits(32'hFF, 8, r);
        exp_q.push_back({8'hFF, 32'h1111_1111});
        spi_bits(32'h1111_1111, 32, r);
        exp_q.push_back({8'h00, 32'h2222_2222});
        spi_bits(32'h2222_2222, 32, r);
        frame_end();
        chk("wrap_wc", {55'b0, word_count}, 64'd2);
        chk("wrap_q", exp_q.size(), 0);
        chk("wrap_ram0", {32'b0, ram[0]}, 64'h2222_2222);

        frame_start();
        spi_bits(32'hA5, 8, r);
        spi_bits(32'h10, 8, r);
        exp_q.push_back({8'h10, 32'h3333_3333});
        spi_bits(32'h3333_3333, 32, r);
        spi_bits(32'hABCDE, 20, r);
        frame_end();
        chk("abort_wc", {55'b0, word_count}, 64'd1);
        chk("abort_q", exp_q.size(), 0);
        chk("abort_ram", {32'b0, ram[8'h11]}, 64'hxxxx_xxxx);

        frame_start();
        spi_bits(32'h2D, 7, r);
        mosi = 1'b0;
        wait_clks(HALF);
        sclk = 1'b1;
        wait_clks(3);
        chk("run_t3", {63'b0, cpu_hold}, 64'd1);
        wait_clks(1);
        chk("run_t4", {63'b0, cpu_hold}, 64'd0);
        wait_clks(HALF - 4);
        sclk = 1'b0;
        frame_end();
        chk("run_hold", {63'b0, cpu_hold}, 64'd0);

        frame_start();
        spi_bits(32'hA5, 8, r);
        spi_bits(32'h00, 8, r);
        spi_bits(32'hDEAD_BEEF, 32, r);
        frame_end();
        chk("refuse_hold", {63'b0, cpu_hold}, 64'd0);
        chk("refuse_wc", {55'b0, word_count}, 64'd1);
        chk("refuse_ram", {32'b0, ram[0]}, 64'h2222_2222);

        frame_start();
        spi_bits(32'hC3, 8, r);
        frame_end();
        chk("hold_set", {63'b0, cpu_hold}, 64'd1);
        chk("end_q", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
